alu_mdu_seq: RTL and testbench

//  Parametrised successor ALU for the multicycle MIPS datapath. Executes the 8 base logic/arith ops

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mdu_core.sv | 104 ++++++++++
 rtl/alu_mdu_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, command width and FSM state encoding for alu_mdu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_CMD_W = 4;

    localparam logic [ALU_CMD_W-1:0] c_OP_ADD   = 4'd0;
    localparam logic [ALU_CMD_W-1:0] c_OP_SUB   = 4'd1;
    localparam logic [ALU_CMD_W-1:0] c_OP_XOR   = 4'd2;
    localparam logic [ALU_CMD_W-1:0] c_OP_SLT   = 4'd3;
    localparam logic [ALU_CMD_W-1:0] c_OP_AND   = 4'd4;
    localparam logic [ALU_CMD_W-1:0] c_OP_NAND  = 4'd5;
    localparam logic [ALU_CMD_W-1:0] c_OP_NOR   = 4'd6;
    localparam logic [ALU_CMD_W-1:0] c_OP_OR    = 4'd7;
    localparam logic [ALU_CMD_W-1:0] c_OP_SLTU  = 4'd8;
    localparam logic [ALU_CMD_W-1:0] c_OP_MULT  = 4'd9;
    localparam logic [ALU_CMD_W-1:0] c_OP_MULTU = 4'd10;
    localparam logic [ALU_CMD_W-1:0] c_OP_DIV   = 4'd11;
    localparam logic [ALU_CMD_W-1:0] c_OP_DIVU  = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_mdu_core.sv
// ============================================================================
// Module      : alu_mdu_core
// Description : Iterative radix-2 multiply / restoring divide on operand
//               magnitudes, with combinational sign fixup of the final value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_go,
    input  logic             i_op_div,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    output logic             o_fin,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int c_CNT_W = $clog2(WIDTH);

    logic               r_active;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_prod;

    assign w_abs_a = (i_is_signed && i_opa[WIDTH-1]) ? -i_opa : i_opa;
    assign w_abs_b = (i_is_signed && i_opb[WIDTH-1]) ? -i_opb : i_opb;

    // Multiply: hi accumulates, lo holds the multiplier and receives product bits.
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
    // The trial difference is below r_b whenever taken, so WIDTH bits suffice.
    assign w_shift    = {r_hi, r_lo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
        end else if (i_go) begin
            r_active  <= 1'b1;
            r_cnt     <= '0;
            r_div     <= i_op_div;
            r_neg_res <= i_is_signed && (i_opa[WIDTH-1] ^ i_opb[WIDTH-1]);
            r_neg_rem <= i_is_signed && i_opa[WIDTH-1];
            r_hi      <= '0;
            r_lo      <= w_abs_a;
            r_b       <= w_abs_b;
        end else if (r_active) begin
            if (r_div) begin
                r_hi <= w_rem_next;
                r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (o_fin) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_fin = r_active && (r_cnt == c_CNT_W'(WIDTH-1));

    assign w_prod = r_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};

    always_comb begin
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            // Truncating division: remainder follows the dividend's sign.
            o_hi = r_neg_rem ? -r_hi : r_hi;
            o_lo = r_neg_res ? -r_lo : r_lo;
        end
    end

endmodule : alu_mdu_core

`default_nettype wire

// File: rtl/alu_mdu_seq.sv
// ============================================================================
// Module      : alu_mdu_seq
// Description : Multicycle ALU with single-cycle logic/arith ops and iterative
//               multiply/divide behind a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ALU_CMD_W-1:0] command,
    input  logic [WIDTH-1:0]     operandA,
    input  logic [WIDTH-1:0]     operandB,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     hi,
    output logic                 zero,
    output logic                 overflow,
    output logic                 carryout
);

    localparam logic [WIDTH-1:0] c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    state_t           w_next;
    logic             w_go;
    logic             w_accept;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_overflow;
    logic             r_carryout;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_div_zero;
    logic             w_div_ovf;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_hi;
    logic             w_ovf;
    logic             w_cout;

    logic             w_fin;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    assign w_is_mul    = (command == c_OP_MULT) || (command == c_OP_MULTU);
    assign w_is_div    = (command == c_OP_DIV)  || (command == c_OP_DIVU);
    assign w_is_signed = (command == c_OP_MULT) || (command == c_OP_DIV);
    assign w_div_zero  = (operandB == '0);
    assign w_div_ovf   = (command == c_OP_DIV) && (operandA == c_MIN) && (operandB == '1);

    assign w_sum  = {1'b0, operandA} + {1'b0, operandB};
    assign w_diff = {1'b0, operandA} + {1'b0, ~operandB} + 1'b1;

    always_comb begin
        w_res  = '0;
        w_hi   = '0;
        w_ovf  = 1'b0;
        w_cout = 1'b0;
        case (command)
            c_OP_ADD: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_res  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
                w_ovf  = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                         (w_diff[WIDTH-1] != operandA[WIDTH-1]);
            end
            c_OP_XOR:  w_res = operandA ^ operandB;
            c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
            c_OP_AND:  w_res = operandA & operandB;
            c_OP_NAND: w_res = ~(operandA & operandB);
            c_OP_NOR:  w_res = ~(operandA | operandB);
            c_OP_OR:   w_res = operandA | operandB;
            c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (operandA < operandB)};
            c_OP_DIV, c_OP_DIVU: begin
                // Only the short-circuit divide cases complete in one cycle.
                if (w_div_zero) begin
                    w_res = '1;
                    w_hi  = operandA;
                end else if (w_div_ovf) begin
                    w_res = c_MIN;
                    w_ovf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next = S_IDLE;
                if (start) begin
                    if (w_is_mul) begin
                        w_next = S_MUL;
                        w_go   = 1'b1;
                    end else if (w_is_div && !w_div_zero && !w_div_ovf) begin
                        w_next = S_DIV;
                        w_go   = 1'b1;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (w_fin) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_hi       <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_carryout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && (w_next == S_DONE)) begin
                r_result   <= w_res;
                r_hi       <= w_hi;
                r_zero     <= (w_res == '0);
                r_overflow <= w_ovf;
                r_carryout <= w_cout;
            end else if (r_state == S_FIX) begin
                r_result   <= w_core_lo;
                r_hi       <= w_core_hi;
                r_zero     <= (w_core_lo == '0);
                r_overflow <= 1'b0;
                r_carryout <= 1'b0;
            end
        end
    end

    alu_mdu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (reset),
        .i_go        (w_go),
        .i_op_div    (w_is_div),
        .i_is_signed (w_is_signed),
        .i_opa       (operandA),
        .i_opb       (operandB),
        .o_fin       (w_fin),
        .o_hi        (w_core_hi),
        .o_lo        (w_core_lo)
    );

    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign hi       = r_hi;
    assign zero     = r_zero;
    assign overflow = r_overflow;
    assign carryout = r_carryout;

endmodule : alu_mdu_seq

`default_nettype wire

// File: tb/tb_alu_mdu_seq.sv
// ============================================================================
// Module      : tb_alu_mdu_seq
// Description : Directed self-checking bench for alu_mdu_seq (WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  command;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi;
    logic        zero;
    logic        overflow;
    logic        carryout;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mdu_seq #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .command  (command),
        .operandA (operandA),
        .operandB (operandB),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .zero     (zero),
        .overflow (overflow),
        .carryout (carryout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op and return cycles from the accepting edge until done.
    task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        start    = 1'b1;
        command  = cmd;
        operandA = a;
        operandB = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int seen_done;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        command  = 4'd0;
        operandA = '0;
        operandB = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_out", {done, busy, zero, overflow, carryout, result, hi}, 69'd0);

        run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
        check("add_lat", lat, 1);
        check("add_res", result, 32'h8000_0000);
        check("add_flags", {zero, overflow, carryout}, 3'b010);

        run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
        check("add_carry", {result, zero, overflow, carryout}, {32'h0, 3'b101});

        run_op(4'd1, 32'd5, 32'd5, lat);
        check("sub_eq", {result, zero, overflow, carryout}, {32'h0, 3'b101});

        run_op(4'd1, 32'd3, 32'd5, lat);
        check("sub_borrow", {result, zero, overflow, carryout}, {32'hFFFF_FFFE, 3'b000});

        run_op(4'd1, 32'h8000_0000, 32'd1, lat);
        check("sub_ovf", {result, zero, overflow, carryout}, {32'h7FFF_FFFF, 3'b011});

        run_op(4'd3, 32'hFFFF_FFFF, 32'd1, lat);
        check("slt", {result, hi}, {32'd1, 32'd0});

        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, lat);
        check("sltu", {result, zero}, {32'd0, 1'b1});

        run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_4321, lat);
        check("xor", result, 32'hFF00_5115);
        run_op(4'd4, 32'hF0F0_1234, 32'h0FF0_4321, lat);
        check("and", result, 32'h00F0_0220);
        run_op(4'd5, 32'hF0F0_1234, 32'h0FF0_4321, lat);
        check("nand", result, 32'hFF0F_FDDF);
        run_op(4'd6, 32'hF0F0_1234, 32'h0FF0_4321, lat);
        check("nor", result, 32'h000F_ACCA);
        run_op(4'd7, 32'hF0F0_1234, 32'h0FF0_4321, lat);
        check("or", result, 32'hFFF0_5335);

        run_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, lat);
        check("reserved", {lat, result, hi, overflow, carryout}, {32'd1, 32'd0, 32'd0, 2'b00});

        run_op(4'd9, 32'hFFFF_FFFD, 32'd7, lat);
        check("mult_lat", lat, 34);
        check("mult_val", {hi, result}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_val", {hi, result}, 64'hFFFF_FFFE_0000_0001);
        check("multu_flags", {zero, overflow, carryout}, 3'b000);

        run_op(4'd11, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lat", lat, 34);
        check("div_neg", {hi, result}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(4'd11, 32'd7, 32'hFFFF_FFFE, lat);
        check("div_negdiv", {hi, result}, 64'h0000_0001_FFFF_FFFD);

        run_op(4'd12, 32'd100, 32'd7, lat);
        check("divu", {hi, result}, {32'd2, 32'd14});

        run_op(4'd12, 32'd7, 32'd0, lat);
        check("divu_zero", {lat, result, hi, overflow}, {32'd1, 32'hFFFF_FFFF, 32'd7, 1'b0});

        run_op(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_ovf", {lat, result, hi, overflow}, {32'd1, 32'h8000_0000, 32'd0, 1'b1});

        // Start while busy must be ignored, as must operand changes after launch.
        @(negedge clk);
        start    = 1'b1;
        command  = 4'd9;
        operandA = 32'd6;
        operandB = 32'd7;
        @(negedge clk);
        start    = 1'b0;
        operandA = 32'd100;
        operandB = 32'd100;
        lat      = 1;
        check("mult_busy", busy, 1'b1);
        repeat (4) begin
            @(negedge clk);
            lat++;
        end
        start    = 1'b1;
        command  = 4'd0;
        operandA = 32'd1;
        operandB = 32'd1;
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("busy_ign_lat", lat, 34);
        check("busy_ign_val", {hi, result}, 64'd42);

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        start    = 1'b1;
        command  = 4'd9;
        operandA = 32'hFFFF_FFFD;
        operandB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid", {done, busy, zero, overflow, carryout, result, hi}, 69'd0);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        check("rst_nodone", seen_done, 0);

        run_op(4'd0, 32'd2, 32'd3, lat);
        check("post_rst_add", {lat, result}, {32'd1, 32'd5});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_alu_mdu_seq

`default_nettype wire
